decode_redirect: RTL and testbench

- ID/EX-side counterpart of the fetch stage. Latches the fetched instruction and its PC into ID and EX slots.
- Decodes J/JAL in ID and BEQ/BNE in EX. Detects load-use hazards.
- Drives fetch's redirect/stall interface: Jump_ID, JumpTgt_ID, BranchTaken_EX, RedirectPc_EX, AnyStall. Squashes wrong-path instructions in its own slots.

---
 rtl/decode_redirect_pkg.sv | 51 +++++
 rtl/decode_redirect_hazard_unit.sv | 39 +++
 rtl/dff.sv | 21 ++
 rtl/decode_redirect.sv | 101 ++++++++++
 tb/tb_decode_redirect.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_redirect_pkg.sv
// Shared opcode constants, instruction field ranges and the ID/EX slot payload.
package decode_redirect_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2b;

    // One pipeline slot: instruction word plus its PC.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } slot_t;

    localparam int unsigned SLOT_W = $bits(slot_t);

    function automatic logic [OPC_W-1:0] get_opcode(input logic [XLEN-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [REG_W-1:0] get_rs(input logic [XLEN-1:0] w);
        return w[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_W-1:0] get_rt(input logic [XLEN-1:0] w);
        return w[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm(input logic [XLEN-1:0] w);
        return w[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/decode_redirect_hazard_unit.sv
// Load-use hazard detection between the EX-slot load and the ID-slot consumer.
module hazard_unit
    import decode_redirect_pkg::*;
(
    input  logic [XLEN-1:0] Instr_ID,
    input  logic [XLEN-1:0] Instr_EX,
    input  logic            BranchTaken_EX,
    output logic            AnyStall
);

    logic [OPC_W-1:0] op_id;
    logic [OPC_W-1:0] op_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic [REG_W-1:0] rt_ex;
    logic             load_ex;
    logic             reads_rt;
    logic             hazard;
    logic             unused_bits;

    // Only opcode and register fields participate in the comparison.
    assign unused_bits = ^{Instr_ID[IMM_MSB:IMM_LSB], Instr_EX[RS_MSB:RS_LSB],
                           Instr_EX[IMM_MSB:IMM_LSB]};

    // Hazard when a live load in EX writes a register the ID instruction reads.
    always_comb begin
        op_id    = get_opcode(Instr_ID);
        op_ex    = get_opcode(Instr_EX);
        rs_id    = get_rs(Instr_ID);
        rt_id    = get_rt(Instr_ID);
        rt_ex    = get_rt(Instr_EX);
        load_ex  = (op_ex == OP_LW) && (rt_ex != '0);
        reads_rt = (op_id == OP_RTYPE) || (op_id == OP_BEQ) ||
                   (op_id == OP_BNE)   || (op_id == OP_SW);
        hazard   = load_ex && ((rt_ex == rs_id) || (reads_rt && (rt_ex == rt_id)));
        AnyStall = hazard && !BranchTaken_EX;
    end

endmodule

// File: rtl/dff.sv
// Generic register with asynchronous active-high reset to a parameterised value.
module dff #(
    parameter int unsigned     W         = 1,
    parameter logic [W-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage with asynchronous clear to RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode_redirect.sv
// ID/EX slots with jump decode, branch resolution, load-use stall and squash.
module decode_redirect
    import decode_redirect_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] FetchData_IF,
    input  logic [31:0] Pc_IF,
    input  logic [31:0] RsVal_EX,
    input  logic [31:0] RtVal_EX,
    output logic [31:0] Instr_ID,
    output logic [31:0] Pc_ID,
    output logic [31:0] Instr_EX,
    output logic [31:0] Pc_EX,
    output logic        AnyStall,
    output logic        Jump_ID,
    output logic [25:0] JumpTgt_ID,
    output logic        BranchTaken_EX,
    output logic [31:0] RedirectPc_EX
);

    localparam logic [SLOT_W-1:0] SLOT_RESET = {NOP_WORD, 32'h00000000};

    slot_t           id_q;
    slot_t           ex_q;
    slot_t           id_d;
    slot_t           ex_d;
    slot_t           bubble;
    logic [OPC_W-1:0] op_id;
    logic [OPC_W-1:0] op_ex;
    logic [IMM_W-1:0] imm_ex;
    logic [XLEN-1:0]  br_offset;

    dff #(.W(SLOT_W), .RESET_VAL(SLOT_RESET)) u_id_slot (
        .clk   (clk),
        .reset (reset),
        .d     (id_d),
        .q     (id_q)
    );

    dff #(.W(SLOT_W), .RESET_VAL(SLOT_RESET)) u_ex_slot (
        .clk   (clk),
        .reset (reset),
        .d     (ex_d),
        .q     (ex_q)
    );

    hazard_unit u_hazard (
        .Instr_ID       (id_q.instr),
        .Instr_EX       (ex_q.instr),
        .BranchTaken_EX (BranchTaken_EX),
        .AnyStall       (AnyStall)
    );

    assign Instr_ID   = id_q.instr;
    assign Pc_ID      = id_q.pc;
    assign Instr_EX   = ex_q.instr;
    assign Pc_EX      = ex_q.pc;
    assign JumpTgt_ID = id_q.instr[TGT_W-1:0];

    // Branch resolution and target for the EX-slot instruction.
    always_comb begin
        op_ex          = get_opcode(ex_q.instr);
        imm_ex         = get_imm(ex_q.instr);
        br_offset      = {{14{imm_ex[IMM_W-1]}}, imm_ex, 2'b00};
        RedirectPc_EX  = ex_q.pc + 32'd4 + br_offset;
        BranchTaken_EX = 1'b0;
        case (op_ex)
            OP_BEQ:  BranchTaken_EX = (RsVal_EX == RtVal_EX);
            OP_BNE:  BranchTaken_EX = (RsVal_EX != RtVal_EX);
            default: BranchTaken_EX = 1'b0;
        endcase
    end

    // Jump decode in ID; a resolving branch in EX overrides it.
    always_comb begin
        op_id   = get_opcode(id_q.instr);
        Jump_ID = ((op_id == OP_J) || (op_id == OP_JAL)) && !BranchTaken_EX;
    end

    // Next slot contents: branch squash, then stall, then jump bubble, then advance.
    always_comb begin
        bubble.instr = NOP_WORD;
        bubble.pc    = 32'h00000000;
        id_d.instr   = FetchData_IF;
        id_d.pc      = Pc_IF;
        ex_d         = id_q;
        if (BranchTaken_EX) begin
            id_d = bubble;
            ex_d = bubble;
        end else if (AnyStall) begin
            id_d = id_q;
            ex_d = bubble;
        end else if (Jump_ID) begin
            id_d = bubble;
        end
    end

endmodule

// File: tb/tb_decode_redirect.sv
// Directed self-checking bench for decode_redirect.
module tb_decode_redirect;

    logic        clk;
    logic        reset;
    logic [31:0] FetchData_IF;
    logic [31:0] Pc_IF;
    logic [31:0] RsVal_EX;
    logic [31:0] RtVal_EX;
    logic [31:0] Instr_ID;
    logic [31:0] Pc_ID;
    logic [31:0] Instr_EX;
    logic [31:0] Pc_EX;
    logic        AnyStall;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        BranchTaken_EX;
    logic [31:0] RedirectPc_EX;

    int checks   = 0;
    int failures = 0;

    decode_redirect dut (
        .clk            (clk),
        .reset          (reset),
        .FetchData_IF   (FetchData_IF),
        .Pc_IF          (Pc_IF),
        .RsVal_EX       (RsVal_EX),
        .RtVal_EX       (RtVal_EX),
        .Instr_ID       (Instr_ID),
        .Pc_ID          (Pc_ID),
        .Instr_EX       (Instr_EX),
        .Pc_EX          (Pc_EX),
        .AnyStall       (AnyStall),
        .Jump_ID        (Jump_ID),
        .JumpTgt_ID     (JumpTgt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .RedirectPc_EX  (RedirectPc_EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] instr, input logic [31:0] pc);
        FetchData_IF = instr;
        Pc_IF        = pc;
    endtask

    initial begin
        reset        = 1'b1;
        FetchData_IF = 32'h8c010000;
        Pc_IF        = 32'h4;
        RsVal_EX     = 32'h0;
        RtVal_EX     = 32'h0;

        // Reset held for two edges with a load on the fetch bus.
        tick();
        tick();
        check("rst_instr_id", Instr_ID, 32'h0);
        check("rst_instr_ex", Instr_EX, 32'h0);
        check("rst_pc_id", Pc_ID, 32'h0);
        check("rst_pc_ex", Pc_EX, 32'h0);
        check("rst_stall", 32'(AnyStall), 32'h0);
        check("rst_jump", 32'(Jump_ID), 32'h0);
        check("rst_tgt", 32'(JumpTgt_ID), 32'h0);
        check("rst_taken", 32'(BranchTaken_EX), 32'h0);
        feed(32'h0, 32'h0);
        reset = 1'b0;
        tick();

        // Jump: J captured into ID, then one bubble.
        feed(32'h08000010, 32'h40);
        tick();
        feed(32'h20010001, 32'h44);
        #1;
        check("jmp_instr_id", Instr_ID, 32'h08000010);
        check("jmp_pc_id", Pc_ID, 32'h40);
        check("jmp_flag", 32'(Jump_ID), 32'h1);
        check("jmp_tgt", 32'(JumpTgt_ID), 32'h10);
        check("jmp_stall", 32'(AnyStall), 32'h0);
        tick();
        check("jmp_bubble_id", Instr_ID, 32'h0);
        check("jmp_ex_adv", Instr_EX, 32'h08000010);
        check("jmp_flag_after", 32'(Jump_ID), 32'h0);

        // Taken BEQ at 0x100, wrong-path instruction behind it.
        feed(32'h10220003, 32'h100);
        tick();
        feed(32'h20010001, 32'h104);
        tick();
        feed(32'h20020002, 32'h108);
        RsVal_EX = 32'h5;
        RtVal_EX = 32'h5;
        #1;
        check("beq_instr_ex", Instr_EX, 32'h10220003);
        check("beq_taken", 32'(BranchTaken_EX), 32'h1);
        check("beq_target", RedirectPc_EX, 32'h110);
        check("beq_jump", 32'(Jump_ID), 32'h0);
        tick();
        check("beq_sq_id", Instr_ID, 32'h0);
        check("beq_sq_ex", Instr_EX, 32'h0);
        check("beq_taken_after", 32'(BranchTaken_EX), 32'h0);

        // BNE at 0x200 with negative offset.
        feed(32'h1422fffe, 32'h200);
        tick();
        feed(32'h0, 32'h204);
        tick();
        RsVal_EX = 32'h7;
        RtVal_EX = 32'h7;
        #1;
        check("bne_eq_taken", 32'(BranchTaken_EX), 32'h0);
        check("bne_eq_target", RedirectPc_EX, 32'h1fc);
        RtVal_EX = 32'h8;
        #1;
        check("bne_ne_taken", 32'(BranchTaken_EX), 32'h1);
        check("bne_ne_target", RedirectPc_EX, 32'h1fc);
        tick();
        check("bne_sq_ex", Instr_EX, 32'h0);
        RsVal_EX = 32'h0;
        RtVal_EX = 32'h0;

        // Load-use through rs: one stall cycle, consumer held in ID.
        feed(32'h8c030000, 32'h300);
        tick();
        feed(32'h00631020, 32'h304);
        tick();
        feed(32'h20010001, 32'h308);
        #1;
        check("lu_instr_ex", Instr_EX, 32'h8c030000);
        check("lu_stall", 32'(AnyStall), 32'h1);
        tick();
        check("lu_hold_id", Instr_ID, 32'h00631020);
        check("lu_hold_pc", Pc_ID, 32'h304);
        check("lu_ex_nop", Instr_EX, 32'h0);
        check("lu_stall_clear", 32'(AnyStall), 32'h0);
        tick();
        check("lu_adv_ex", Instr_EX, 32'h00631020);
        check("lu_adv_id", Instr_ID, 32'h20010001);
        check("lu_adv_stall", 32'(AnyStall), 32'h0);

        // Load-use through rt of a store; addi writing the same rt does not stall.
        feed(32'h8c030000, 32'h400);
        tick();
        feed(32'hac030004, 32'h404);
        tick();
        #1;
        check("sw_rt_stall", 32'(AnyStall), 32'h1);
        feed(32'h0, 32'h408);
        tick();
        feed(32'h8c030000, 32'h410);
        tick();
        feed(32'h20030001, 32'h414);
        tick();
        check("addi_rt_nostall", 32'(AnyStall), 32'h0);

        // Load into r0 never creates a hazard.
        feed(32'h8c000000, 32'h500);
        tick();
        feed(32'h00001020, 32'h504);
        tick();
        check("lw_r0_nostall", 32'(AnyStall), 32'h0);
        feed(32'h0, 32'h508);
        tick();
        tick();

        // Taken BEQ in EX while ID holds a J.
        feed(32'h10220003, 32'h600);
        tick();
        feed(32'h08000020, 32'h604);
        tick();
        RsVal_EX = 32'h5;
        RtVal_EX = 32'h5;
        #1;
        check("sim_j_taken", 32'(BranchTaken_EX), 32'h1);
        check("sim_j_jump", 32'(Jump_ID), 32'h0);
        check("sim_j_stall", 32'(AnyStall), 32'h0);
        check("sim_j_target", RedirectPc_EX, 32'h610);
        feed(32'h0, 32'h608);
        tick();
        check("sim_j_sq_id", Instr_ID, 32'h0);
        check("sim_j_sq_ex", Instr_EX, 32'h0);

        // Taken BEQ in EX while ID holds a register-reading add.
        feed(32'h10220003, 32'h700);
        tick();
        feed(32'h00631020, 32'h704);
        tick();
        #1;
        check("sim_add_taken", 32'(BranchTaken_EX), 32'h1);
        check("sim_add_stall", 32'(AnyStall), 32'h0);
        check("sim_add_jump", 32'(Jump_ID), 32'h0);
        feed(32'h0, 32'h708);
        tick();
        check("sim_add_sq_id", Instr_ID, 32'h0);
        check("sim_add_sq_ex", Instr_EX, 32'h0);
        RsVal_EX = 32'h0;
        RtVal_EX = 32'h0;

        // Reset asserted mid-stall clears both slots immediately.
        feed(32'h8c030000, 32'h800);
        tick();
        feed(32'h00631020, 32'h804);
        tick();
        check("mid_stall_pre", 32'(AnyStall), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_id", Instr_ID, 32'h0);
        check("mid_rst_ex", Instr_EX, 32'h0);
        check("mid_rst_stall", 32'(AnyStall), 32'h0);
        tick();
        feed(32'h0, 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_taken", 32'(BranchTaken_EX), 32'h0);
        check("post_rst_jump", 32'(Jump_ID), 32'h0);
        check("post_rst_stall", 32'(AnyStall), 32'h0);

        // Reset asserted while a taken branch is resolving.
        feed(32'h10220003, 32'h900);
        tick();
        feed(32'h20010001, 32'h904);
        tick();
        RsVal_EX = 32'h9;
        RtVal_EX = 32'h9;
        #1;
        check("mid_br_pre", 32'(BranchTaken_EX), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_br_taken", 32'(BranchTaken_EX), 32'h0);
        check("mid_br_ex", Instr_EX, 32'h0);
        tick();
        reset = 1'b0;
        feed(32'h0, 32'h0);
        tick();
        check("mid_br_after", 32'(BranchTaken_EX), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
